// File: rtl/gray_conv_arbiter.sv
// Round-robin shared Gray-to-binary converter with a valid/ready result port.
// Optional per-requester step checker enabled by defining GRAY_STEP_CHECK_EN.
module gray_conv_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_gray,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_bin,
    output logic [IDW-1:0]      out_id,
    output logic                busy,
    output logic                step_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [1:0]     r_state;
    logic [IDW-1:0] r_ptr;
    logic [W-1:0]   r_gray_q;
    logic [IDW-1:0] r_id_q;
    logic           r_out_valid;
    logic [W-1:0]   r_out_bin;
    logic [IDW-1:0] r_out_id;

    logic           w_any;
    logic [IDW-1:0] w_winner;
    logic [IDW-1:0] w_next_ptr;
    logic [W-1:0]   w_bin;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            logic w_hit;
            w_hit    = req_valid[(int'(r_ptr) + k) % NREQ] & ~w_any;
            w_winner = w_hit ? IDW'((int'(r_ptr) + k) % NREQ) : w_winner;
            w_any    = w_any | w_hit;
        end
    end

    assign w_next_ptr = (w_winner == LAST_ID) ? '0 : (w_winner + IDW'(1));
    assign w_bin      = gray2bin(r_gray_q);

    // One-hot grant, only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == ST_IDLE) && w_any) begin
            req_ready[w_winner] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Arbitration / conversion / output-hold state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gray_q    <= '0;
            r_id_q      <= '0;
            r_out_valid <= 1'b0;
            r_out_bin   <= '0;
            r_out_id    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gray_q <= req_gray[int'(w_winner)*W +: W];
                        r_id_q   <= w_winner;
                        r_ptr    <= w_next_ptr;
                        r_state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_out_bin   <= w_bin;
                    r_out_id    <= r_id_q;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [W-1:0]    r_last_bin [NREQ];
    logic [NREQ-1:0] r_seen;
    logic            r_step_err;

    // Track the previous result per requester; a +1 step (with wrap) is legal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                r_last_bin[i] <= '0;
            end
            r_seen     <= '0;
            r_step_err <= 1'b0;
        end else if (r_state == ST_CONV) begin
            r_step_err         <= r_seen[r_id_q] & (w_bin != (r_last_bin[r_id_q] + W'(1)));
            r_last_bin[r_id_q] <= w_bin;
            r_seen[r_id_q]     <= 1'b1;
        end
    end

    assign step_err = r_step_err;
`else
    assign step_err = 1'b0;
`endif

    assign out_valid = r_out_valid;
    assign out_bin   = r_out_bin;
    assign out_id    = r_out_id;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed-vector bench for gray_conv_arbiter (NREQ=4, W=4).
module tb_gray_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_gray;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_bin;
    logic [1:0]  out_id;
    logic        busy;
    logic        step_err;

    int n_total = 0;
    int n_bad   = 0;

    gray_conv_arbiter #(.NREQ(4), .W(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_gray  (req_gray),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_id    (out_id),
        .busy      (busy),
        .step_err  (step_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction from requester id; expected step flag applies only with the checker built in.
    task automatic one(input int id, input logic [3:0] g, input logic [3:0] b, input logic e_chk);
        logic e;
`ifdef GRAY_STEP_CHECK_EN
        e = e_chk;
`else
        e = 1'b0;
`endif
        req_gray[id*4 +: 4] = g;
        req_valid           = 4'b0000;
        req_valid[id]       = 1'b1;
        #1;
        chk("grant", 32'(req_ready), 32'd1 << id);
        tick();
        req_valid = 4'b0000;
        chk("conv_busy", 32'(busy), 32'd1);
        chk("conv_valid", 32'(out_valid), 32'd0);
        chk("conv_ready", 32'(req_ready), 32'd0);
        tick();
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_bin", 32'(out_bin), 32'(b));
        chk("out_id", 32'(out_id), 32'(id));
        chk("step_err", 32'(step_err), 32'(e));
        out_ready = 1'b1;
        tick();
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        out_ready = 1'b0;
    endtask

    logic [3:0] g1 [6] = '{4'b1011, 4'b1111, 4'b1000, 4'b1001, 4'b0011, 4'b1101};
    logic [3:0] b1 [6] = '{4'd13, 4'd10, 4'd15, 4'd14, 4'd2, 4'd9};
    logic       e1 [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] g2 [4] = '{4'b1001, 4'b1000, 4'b0000, 4'b0111};
    logic [3:0] b2 [4] = '{4'd14, 4'd15, 4'd0, 4'd5};
    logic       e2 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] rr_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       rr_e  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_gray  = 16'h0000;
        out_ready = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bin", 32'(out_bin), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        chk("rst_err", 32'(step_err), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n     = 1'b1;
        req_valid = 4'h0;
        tick();

        // Stray out_ready while idle.
        out_ready = 1'b1;
        tick();
        chk("idle_rdy_valid", 32'(out_valid), 32'd0);
        chk("idle_rdy_busy", 32'(busy), 32'd0);
        out_ready = 1'b0;

        for (int i = 0; i < 6; i++) begin
            one(0, g1[i], b1[i], e1[i]);
        end

        // Stall in OUT for 5 clocks while requester 3 waits.
        req_gray[7:4] = 4'b0110;
        req_valid     = 4'b0010;
        #1;
        chk("st_grant", 32'(req_ready), 32'd2);
        tick();
        req_valid      = 4'b1000;
        req_gray[15:12] = 4'b0101;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("st_valid", 32'(out_valid), 32'd1);
            chk("st_bin", 32'(out_bin), 32'd4);
            chk("st_id", 32'(out_id), 32'd1);
            chk("st_err", 32'(step_err), 32'd0);
            chk("st_ready", 32'(req_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("st_idle_busy", 32'(busy), 32'd0);
        chk("st_idle_valid", 32'(out_valid), 32'd0);
        chk("st_idle_grant", 32'(req_ready), 32'd8);
        req_valid = 4'b0000;
        out_ready = 1'b0;

        // Reset while in CONV.
        req_gray[11:8] = 4'b0001;
        req_valid      = 4'b0100;
        #1;
        chk("rc_grant", 32'(req_ready), 32'd4);
        tick();
        req_valid = 4'b1000;
        rst_n     = 1'b0;
        #1;
        chk("rc_valid", 32'(out_valid), 32'd0);
        chk("rc_busy", 32'(busy), 32'd0);
        chk("rc_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        req_gray  = {4'b0010, 4'b0011, 4'b0001, 4'b0000};
        req_valid = 4'hF;
        out_ready = 1'b1;

        // All four requesting: grants 0,1,2,3,0 every 3 clocks.
        for (int i = 0; i < 5; i++) begin
            logic e;
`ifdef GRAY_STEP_CHECK_EN
            e = rr_e[i];
`else
            e = 1'b0;
`endif
            #1;
            chk("rr_grant", 32'(req_ready), 32'd1 << rr_id[i]);
            tick();
            chk("rr_conv_ready", 32'(req_ready), 32'd0);
            tick();
            chk("rr_valid", 32'(out_valid), 32'd1);
            chk("rr_id", 32'(out_id), 32'(rr_id[i]));
            chk("rr_bin", 32'(out_bin), 32'(rr_id[i]));
            chk("rr_err", 32'(step_err), 32'(e));
            chk("rr_out_ready", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 4'b0000;
        out_ready = 1'b0;

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            one(2, g2[i], b2[i], e2[i]);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
Shares one registered Gray-to-binary conversion datapath among NREQ requesters. A round-robin arbiter grants one requester at a time and captures its Gray code. The block converts it and presents the binary result with the requester ID on a valid/ready output port. It sits between Gray-coded sources (pointers, encoder positions) and binary consumers.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, Gray/binary word width (2..16)
IDW, 2, ID width; must equal clog2(NREQ), min 1

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request; bit i = requester i
req_gray  in  NREQ*W  Gray codes; requester i at bits [i*W +: W]
req_ready  out  NREQ  one-hot grant/accept, combinational
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_bin  out  W  converted binary value
out_id  out  IDW  requester index of result
busy  out  1  high in any state other than IDLE
step_err  out  1  sequence-check flag, qualified by out_valid (see Optional Feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset, asynchronous on rst_n low:
  - FSM goes to IDLE; RR pointer = 0.
  - out_valid=0, out_bin=0, out_id=0, step_err=0, busy=0.
  - req_ready is combinationally 0 while in reset.
  - Reset mid-operation discards any in-flight result; no partial output is emitted.
- FSM states: IDLE, CONV, OUT.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching ptr, ptr+1, ... mod NREQ.
  - req_ready[winner]=1 in that cycle only; all other req_ready bits are 0.
  - On the clock edge: gray_q <= winner's word, id_q <= winner, ptr <= (winner+1) mod NREQ, next state CONV.
  - If no req_valid is set, stay in IDLE and leave ptr unchanged.
- CONV:
  - out_bin <= bin(gray_q), out_id <= id_q, out_valid <= 1, next state OUT.
  - bin[W-1] = g[W-1]; bin[i] = bin[i+1] ^ g[i] for i = W-2..0.
- OUT:
  - Hold out_valid, out_bin, out_id and step_err stable until out_ready=1.
  - On the edge where out_valid & out_ready: out_valid <= 0, next state IDLE.
- req_ready is 0 in CONV and OUT.
- Latency: grant edge to out_valid high is 2 clocks. Minimum issue interval is 3 clocks per result.
- Requesters hold req_valid and req_gray stable until they see req_ready. Deasserting before the grant is legal; that request is simply not granted.
- Fairness: a continuously requesting requester is granted within NREQ grants.
- All NREQ requests asserted together are granted in order ptr, ptr+1, ... with wrap-around from NREQ-1 to 0.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
Macro GRAY_STEP_CHECK_EN.
- Defined:
  - Per requester, keep last_bin[W] and seen (1 bit), both cleared by reset.
  - In CONV, step_err <= seen[id_q] & (bin != last_bin[id_q] + 1 mod 2^W). In the same cycle, last_bin[id_q] <= bin and seen[id_q] <= 1.
  - Wrap from 2^W-1 to 0 is a legal step.
- Not defined: step_err is tied to 0 and no per-requester storage exists. The port is always present.

Test Plan:
- Reset, then requester 0 sends gray 1011 -> out_valid 2 clocks after grant, out_bin=1101 (13), out_id=0. Then 1111 -> 1010, 1000 -> 1111, 1001 -> 1110, 0011 -> 0010, 1101 -> 1001.
- All 4 req_valid held high with distinct codes, out_ready=1 -> out_id sequence 0,1,2,3,0; each req_ready pulse is one-hot and 1 clock wide; results arrive every 3 clocks.
- out_ready held low for 5 clocks in OUT -> out_valid, out_bin and out_id stay stable; req_ready stays 0 for all requesters; IDLE is re-entered 1 clock after out_ready rises.
- rst_n pulsed low during CONV -> out_valid=0 and busy=0 immediately; the next grant goes to requester 0.
- Requester 2 only, sending gray of 14, 15, 0 then 5 (1001, 1000, 0000, 0111) -> outputs 14, 15, 0, 5; with GRAY_STEP_CHECK_EN, step_err = 0, 0, 0, 1; without the macro, step_err is always 0.
